// File: rtl/imm_encoder_if.sv
// Stream bundle between the program loader and the immediate encoder.
// The master is the loader side and the slave is the encoder.
interface imm_encoder_if #(
    parameter int ADDR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_fmt;
    logic [2:0]         in_funct3;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic signed [31:0] in_imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic [ADDR_W-1:0]  out_addr;
    logic               err;
    logic [1:0]         err_code;
    logic               clr_err;

    modport master (
        output in_valid, in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        output out_ready, clr_err,
        input  in_ready, out_valid, out_instr, out_addr, err, err_code
    );

    modport slave (
        input  in_valid, in_fmt, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
        input  out_ready, clr_err,
        output in_ready, out_valid, out_instr, out_addr, err, err_code
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs decoded fields and a signed immediate into RV32I I/S/B words,
// range-checks the immediate and tags each word with its program address.
module imm_encoder #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int          ADDR_W    = 32
) (
    input logic          clk,
    input logic          rst,
    imm_encoder_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, FULL, HALT} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    function automatic logic [6:0] opcode(input logic [1:0] fmt);
        case (fmt)
            2'b00:   return 7'b0000011;
            2'b01:   return 7'b0010011;
            2'b10:   return 7'b0100011;
            default: return 7'b1100011;
        endcase
    endfunction

    function automatic logic [31:0] encode(
        input logic [1:0]  fmt,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        case (fmt)
            2'b00, 2'b01: return {imm[11:0], rs1, f3, rd, opcode(fmt)};
            2'b10:        return {imm[11:5], rs2, rs1, f3, imm[4:0], opcode(fmt)};
            default:      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode(fmt)};
        endcase
    endfunction

    // Overflow outranks an odd branch offset when both apply.
    function automatic logic [1:0] range_code(
        input logic [1:0]         fmt,
        input logic signed [31:0] imm
    );
        logic signed [31:0] lo;
        logic signed [31:0] hi;
        lo = (fmt == 2'b11) ? -32'sd4096 : -32'sd2048;
        hi = (fmt == 2'b11) ?  32'sd4094 :  32'sd2047;
        if (imm < lo || imm > hi)
            return 2'b01;
        else if (fmt == 2'b11 && imm[0])
            return 2'b10;
        else
            return 2'b00;
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        code_q, code_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;

    logic              in_ready_c;
    logic              accept;
    logic              out_hs;
    logic [1:0]        new_code;
    logic [31:0]       new_word;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        code_d     = code_q;
        in_ready_c = !rst && ((state_q == EMPTY) || (state_q == FULL && bus.out_ready));
        accept     = bus.in_valid && in_ready_c;
        out_hs     = (state_q == FULL) && bus.out_ready;
        new_code   = range_code(bus.in_fmt, bus.in_imm);
        new_word   = encode(bus.in_fmt, bus.in_funct3, bus.in_rd, bus.in_rs1,
                            bus.in_rs2, bus.in_imm[12:0]);

        if (out_hs) begin
            addr_d  = addr_q + ADDR_W'(4);
            state_d = EMPTY;
        end
        // A rejected request never reaches the output, so it consumes no address.
        if (accept) begin
            if (new_code == 2'b00) begin
                instr_d = new_word;
                state_d = FULL;
            end else begin
                code_d  = new_code;
                state_d = HALT;
            end
        end
        if (state_q == HALT && bus.clr_err) begin
            code_d  = 2'b00;
            state_d = EMPTY;
        end

        vld_d = (state_d == FULL);
        err_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            instr_q <= '0;
            addr_q  <= BASE;
            code_q  <= 2'b00;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: vector table, directed stream sequences and a
// randomized run checked against a one-entry queue reference model.
module tb_imm_encoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_encoder_if #(.ADDR_W(32)) bus ();
    imm_encoder_if #(.ADDR_W(4))  bus4 ();

    imm_encoder #(.BASE_ADDR(0), .ADDR_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
    imm_encoder #(.BASE_ADDR(0), .ADDR_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [1:0]  fmt;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        logic [1:0]  code;
    } vec_t;

    vec_t tbl[16];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        bus.in_fmt    = v.fmt;
        bus.in_funct3 = v.f3;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_imm    = v.imm;
    endtask

    // Reference encoder: fields placed by weight, not by bit concatenation.
    function automatic logic [31:0] ref_word(input logic [1:0] fmt, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [31:0] imm);
        int unsigned u, lo12, b, base, res;
        u    = imm;
        lo12 = u % 4096;
        b    = u % 8192;
        base = 32'(f3) * 4096 + 32'(rs1) * 32768;
        case (fmt)
            2'd0:    res = 3  + base + 32'(rd) * 128 + lo12 * 1048576;
            2'd1:    res = 19 + base + 32'(rd) * 128 + lo12 * 1048576;
            2'd2:    res = 35 + base + 32'(rs2) * 1048576 + (lo12 % 32) * 128
                           + (lo12 / 32) * 33554432;
            default: res = 99 + base + 32'(rs2) * 1048576 + ((b / 2) % 16) * 256
                           + ((b / 2048) % 2) * 128 + ((b / 32) % 64) * 33554432
                           + (b / 4096) * 32'h8000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] ref_code(input logic [1:0] fmt, input logic [31:0] imm);
        int v;
        v = imm;
        if (fmt == 2'd3) begin
            if (v < -4096 || v > 4094) return 2'd1;
            if (v % 2 != 0)            return 2'd2;
            return 2'd0;
        end
        if (v < -2048 || v > 2047) return 2'd1;
        return 2'd0;
    endfunction

    logic [31:0] mq[$];
    logic [31:0] m_addr;
    bit          m_halt;
    logic [1:0]  m_code;

    initial begin
        logic [31:0] exp_addr;
        rst = 1'b1;
        bus.in_valid = 0;  bus.out_ready = 0; bus.clr_err = 0;
        bus.in_fmt = 0; bus.in_funct3 = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;
        bus4.in_valid = 0; bus4.out_ready = 0; bus4.clr_err = 0;
        bus4.in_fmt = 2'd1; bus4.in_funct3 = 0; bus4.in_rd = 5'd1; bus4.in_rs1 = 0; bus4.in_rs2 = 0; bus4.in_imm = 0;

        //            fmt   f3    rd     rs1    rs2    imm            word           code
        tbl[0]  = '{2'd1, 3'd0, 5'd1,  5'd2,  5'd9,  32'hFFFF_FFFF, 32'hFFF1_0093, 2'd0};
        tbl[1]  = '{2'd2, 3'd2, 5'd31, 5'd2,  5'd5,  32'h0000_0008, 32'h0051_2423, 2'd0};
        tbl[2]  = '{2'd3, 3'd0, 5'd7,  5'd1,  5'd2,  32'hFFFF_FFF8, 32'hFE20_8CE3, 2'd0};
        tbl[3]  = '{2'd0, 3'd2, 5'd5,  5'd10, 5'd0,  32'h0000_07FF, 32'h7FF5_2283, 2'd0};
        tbl[4]  = '{2'd0, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFF_F800, 32'h8000_0003, 2'd0};
        tbl[5]  = '{2'd1, 3'd5, 5'd3,  5'd4,  5'd0,  32'h0000_0405, 32'h4052_5193, 2'd0};
        tbl[6]  = '{2'd3, 3'd1, 5'd0,  5'd0,  5'd0,  32'h0000_0FFE, 32'h7E00_1FE3, 2'd0};
        tbl[7]  = '{2'd3, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFF_F000, 32'h8000_0063, 2'd0};
        tbl[8]  = '{2'd2, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFF_F800, 32'h8000_0023, 2'd0};
        tbl[9]  = '{2'd1, 3'd0, 5'd1,  5'd2,  5'd0,  32'h0000_0800, 32'h0,         2'd1};
        tbl[10] = '{2'd3, 3'd0, 5'd0,  5'd0,  5'd0,  32'h0000_0003, 32'h0,         2'd2};
        tbl[11] = '{2'd3, 3'd0, 5'd0,  5'd0,  5'd0,  32'h0000_1000, 32'h0,         2'd1};
        tbl[12] = '{2'd3, 3'd0, 5'd0,  5'd0,  5'd0,  32'h0000_0FFF, 32'h0,         2'd1};
        tbl[13] = '{2'd2, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFF_F7FF, 32'h0,         2'd1};
        tbl[14] = '{2'd0, 3'd0, 5'd0,  5'd0,  5'd0,  32'h8000_0000, 32'h0,         2'd1};
        tbl[15] = '{2'd3, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFF_EFFF, 32'h0,         2'd1};

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_addr", bus.out_addr, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_code", 32'(bus.err_code), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Vector table: one transaction at a time, held then drained
        exp_addr = 0;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            #1;
            if (tbl[i].code == 2'd0) begin
                chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
                chk($sformatf("tbl%0d_instr", i), bus.out_instr, tbl[i].word);
                chk($sformatf("tbl%0d_addr", i), bus.out_addr, exp_addr);
                chk($sformatf("tbl%0d_err", i), 32'(bus.err), 32'd0);
                bus.out_ready = 1'b1;
                tick();
                bus.out_ready = 1'b0;
                exp_addr += 4;
                chk($sformatf("tbl%0d_drained", i), 32'(bus.out_valid), 32'd0);
            end else begin
                chk($sformatf("tbl%0d_err", i), 32'(bus.err), 32'd1);
                chk($sformatf("tbl%0d_code", i), 32'(bus.err_code), 32'(tbl[i].code));
                chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
                chk($sformatf("tbl%0d_no_out", i), 32'(bus.out_valid), 32'd0);
                chk($sformatf("tbl%0d_addr_kept", i), bus.out_addr, exp_addr);
                bus.clr_err = 1'b1;
                tick();
                bus.clr_err = 1'b0;
                chk($sformatf("tbl%0d_cleared", i), 32'(bus.err), 32'd0);
                chk($sformatf("tbl%0d_code_cleared", i), 32'(bus.err_code), 32'd0);
            end
        end

        // Back-to-back store then branch, no bubble
        do_reset();
        bus.out_ready = 1'b1;
        drive(tbl[1]);
        bus.in_valid = 1'b1;
        tick();
        drive(tbl[2]);
        #1;
        chk("b2b_first_instr", bus.out_instr, 32'h0051_2423);
        chk("b2b_first_addr", bus.out_addr, 32'h0);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_second_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_second_instr", bus.out_instr, 32'hFE20_8CE3);
        chk("b2b_second_addr", bus.out_addr, 32'h4);
        tick();
        chk("b2b_idle", 32'(bus.out_valid), 32'd0);
        chk("b2b_next_addr", bus.out_addr, 32'h8);

        // Backpressure with a second request pending
        do_reset();
        bus.out_ready = 1'b0;
        drive(tbl[3]);
        bus.in_valid = 1'b1;
        tick();
        drive(tbl[5]);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
            chk($sformatf("bp%0d_instr", k), bus.out_instr, tbl[3].word);
            chk($sformatf("bp%0d_addr", k), bus.out_addr, 32'h0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_second_instr", bus.out_instr, tbl[5].word);
        chk("bp_second_addr", bus.out_addr, 32'h4);
        tick();
        chk("bp_done_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_done_addr", bus.out_addr, 32'h8);

        // Reset while FULL
        do_reset();
        bus.out_ready = 1'b1;
        drive(tbl[0]);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("rmid_addr_before", bus.out_addr, 32'h4);
        bus.out_ready = 1'b0;
        drive(tbl[4]);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("rmid_full", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmid_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("rmid_addr_reset", bus.out_addr, 32'h0);
        tick();
        rst = 1'b0;
        drive(tbl[0]);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("rmid_after_valid", 32'(bus.out_valid), 32'd1);
        chk("rmid_after_addr", bus.out_addr, 32'h0);
        chk("rmid_after_instr", bus.out_instr, tbl[0].word);

        // Address wrap on the narrow-address instance
        do_reset();
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("wrap%0d_valid", k), 32'(bus4.out_valid), 32'd1);
            chk($sformatf("wrap%0d_addr", k), 32'(bus4.out_addr), 32'((k * 4) % 16));
            tick();
        end
        bus4.in_valid = 1'b0;

        // Randomized stream against the queue model
        do_reset();
        mq.delete();
        m_addr = 0;
        m_halt = 0;
        m_code = 0;
        for (int c = 0; c < 600; c++) begin
            bit          exp_rdy;
            bit          was_halt;
            int          v;
            logic [1:0]  rc;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.clr_err   = ($urandom_range(0, 3) == 0);
            bus.in_fmt    = 2'($urandom_range(0, 3));
            bus.in_funct3 = 3'($urandom_range(0, 7));
            bus.in_rd     = 5'($urandom_range(0, 31));
            bus.in_rs1    = 5'($urandom_range(0, 31));
            bus.in_rs2    = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0)
                v = int'($urandom());
            else if ($urandom_range(0, 7) == 0)
                v = int'($urandom_range(0, 12000)) - 6000;
            else if (bus.in_fmt == 2'd3)
                v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            else
                v = int'($urandom_range(0, 4095)) - 2048;
            bus.in_imm = v;
            #1;
            exp_rdy = !m_halt && (mq.size() == 0 || bus.out_ready);
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            chk("rnd_err", 32'(bus.err), 32'(m_halt));
            chk("rnd_err_code", 32'(bus.err_code), 32'(m_code));
            chk("rnd_addr", bus.out_addr, m_addr);
            if (mq.size() != 0)
                chk("rnd_instr", bus.out_instr, mq[0]);

            was_halt = m_halt;
            if (mq.size() != 0 && bus.out_ready) begin
                void'(mq.pop_front());
                m_addr += 4;
            end
            if (bus.in_valid && exp_rdy) begin
                rc = ref_code(bus.in_fmt, bus.in_imm);
                if (rc == 2'd0)
                    mq.push_back(ref_word(bus.in_fmt, bus.in_funct3, bus.in_rd,
                                          bus.in_rs1, bus.in_rs2, bus.in_imm));
                else begin
                    m_halt = 1;
                    m_code = rc;
                end
            end
            if (was_halt && bus.clr_err) begin
                m_halt = 0;
                m_code = 0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate generator.
- Accepts decoded instruction fields plus a 32-bit signed immediate and packs them into a 32-bit RV32I word in I-load, I-ALU, S or B format.
- Checks that the immediate fits the target format and tags each emitted word with its sequential program address.
- Sits between the test/boot program loader and instruction memory: a valid/ready stream in, a valid/ready stream out, with a one-entry output register.

Parameters:
BASE_ADDR, 0, address assigned to the first emitted word after reset.
ADDR_W, 32, width of out_addr.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid && in_ready.
in_fmt  input  2  00 load (0000011), 01 ALU-imm (0010011), 10 store (0100011), 11 branch (1100011).
in_funct3  input  3  funct3 field.
in_rd  input  5  destination register (I formats only).
in_rs1  input  5  source register 1.
in_rs2  input  5  source register 2 (S/B only).
in_imm  input  32  signed immediate (byte offset for B).
out_valid  output  1  encoded word valid.
out_ready  input  1  consumer ready.
out_instr  output  32  encoded instruction.
out_addr  output  ADDR_W  program address of out_instr.
err  output  1  high while halted on a range error.
err_code  output  2  01 range overflow, 10 odd branch offset, 00 none.
clr_err  input  1  single-cycle pulse, leaves HALT.

Behaviour:
- Reset (asynchronous, active-high):
  - state=EMPTY, out_valid=0, out_instr=0.
  - out_addr=BASE_ADDR, err=0, err_code=00, in_ready=1 once rst deasserts.
- Encoding, opcode from in_fmt:
  - I (load/ALU): [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=opcode.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
  - Unused input fields are ignored.
  - Shifts are passed as an I-ALU immediate with funct7 in imm[11:5] (e.g. srai = 0x400|shamt). No extra check.
- Range checks, on the signed 32-bit in_imm:
  - I/S: -2048..2047.
  - B: -4096..4094; imm[0] must be 0.
  - Overflow gives err_code 01. Odd B offset gives 10. If both apply, 01 wins.
- FSM states: EMPTY, FULL, HALT.
  - EMPTY:
    - in_ready=1, out_valid=0.
    - Accept with good imm: latch encoded word, go to FULL. Latency is 1 cycle from accept to out_valid.
    - Accept with bad imm: go to HALT, latch err_code. Nothing is emitted.
  - FULL:
    - out_valid=1; out_instr and out_addr are held stable until the handshake.
    - in_ready=out_ready.
    - Output handshake only: out_addr += 4, go to EMPTY.
    - Output handshake plus good accept in the same cycle: out_addr += 4, load the new word, stay FULL. Full throughput, 1 word/cycle.
    - Output handshake plus bad accept in the same cycle: the current word completes, out_addr += 4, then go to HALT.
  - HALT:
    - in_ready=0, out_valid=0, err=1.
    - clr_err: go to EMPTY, err=0, err_code=00. out_addr is unchanged.
    - clr_err in any other state is ignored.
- out_addr:
  - Advances only on an output handshake, modulo 2^ADDR_W (wraps silently).
  - Rejected requests consume no address.
  - Between handshakes out_addr equals the address of the next word to be emitted.
- Reset mid-operation discards the held word and restarts the address at BASE_ADDR.

Test Plan:
- Reset, then I-ALU funct3=000 rd=1 rs1=2 imm=0xFFFFFFFF with out_ready=1 -> next cycle out_valid=1, out_instr=0xFFF10093, out_addr=0x0.
- Store funct3=010 rs1=2 rs2=5 imm=8, then branch funct3=000 rs1=1 rs2=2 imm=-8, back-to-back with out_ready=1 -> 0x00512423 @0x0, then 0xFE208CE3 @0x4, no bubble.
- Hold out_ready=0 for 3 cycles while FULL with a second request pending -> in_ready=0, out_instr/out_addr stable. Release -> both words emitted in order, addresses +4 each.
- I-ALU imm=2048 -> no output, err=1, err_code=01, in_ready=0. Pulse clr_err -> EMPTY, err=0; next good word reuses the same address.
- Branch imm=3 -> err_code=10. Branch imm=4096 -> err_code=01.
- Assert rst while FULL -> out_valid drops immediately. After release, the next word has out_addr=BASE_ADDR.
- With ADDR_W=4, emit 5 words -> addresses 0x0, 0x4, 0x8, 0xC, 0x0.
